// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and helpers for the NTT control slice.
// Mode and FSM encodings plus a width-parametrised bit reversal.
package ntt_pkg;

    typedef enum logic [1:0] {
        MODE_DIT = 2'd0,
        MODE_DIF = 2'd1,
        MODE_INV = 2'd2,
        MODE_ILL = 2'd3
    } ntt_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam int MAX_LOG_N = 12;

    // Reverses the low w bits of v; bits at and above w come back as 0.
    function automatic logic [MAX_LOG_N-1:0] bit_reverse(
        input logic [MAX_LOG_N-1:0] v,
        input int                   w
    );
        logic [MAX_LOG_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG_N; i++)
            if (i < w) r[i] = v[w-1-i];
        return r;
    endfunction

endpackage

// File: rtl/ntt_sequencer_if.sv
// ntt_sequencer_if: start/done control plus RAM and twiddle ROM strobes.
// master is the wrapper/datapath side, slave is the sequencer.
interface ntt_sequencer_if #(
    parameter int LOG_N = 8
);
    localparam int SW = $clog2(LOG_N);

    logic             start;
    logic [1:0]       mode;
    logic             stall;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic             rd_en;
    logic [LOG_N-1:0] rd_addr_a;
    logic [LOG_N-1:0] rd_addr_b;
    logic [LOG_N-1:0] tw_addr;
    logic             wr_en;
    logic [LOG_N-1:0] wr_addr_a;
    logic [LOG_N-1:0] wr_addr_b;
    logic [SW-1:0]    stage_idx;

    modport master (
        output start, mode, stall, abort,
        input  busy, done, err, rd_en, rd_addr_a, rd_addr_b,
        input  tw_addr, wr_en, wr_addr_a, wr_addr_b, stage_idx
    );

    modport slave (
        input  start, mode, stall, abort,
        output busy, done, err, rd_en, rd_addr_a, rd_addr_b,
        output tw_addr, wr_en, wr_addr_a, wr_addr_b, stage_idx
    );

endinterface

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: butterfly pair and twiddle address for stage s, index b.
// Purely combinational; DIF walks the half-block size downward.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int LOG_N = 8,
    localparam int SW = $clog2(LOG_N)
) (
    input  ntt_mode_t        mode,
    input  logic [SW-1:0]    s,
    input  logic [LOG_N-1:0] b,
    output logic [LOG_N-1:0] a,
    output logic [LOG_N-1:0] b_addr,
    output logic [LOG_N-1:0] tw
);
    localparam logic [SW-1:0]    LAST = SW'(LOG_N - 1);
    localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

    logic [SW-1:0]        inv_s;
    logic [SW-1:0]        sh;
    logic [LOG_N-1:0]     h, g, p;
    logic [MAX_LOG_N-1:0] rev_in, rev_out;

    always_comb begin
        inv_s   = LAST - s;
        sh      = (mode == MODE_DIF) ? inv_s : s;
        h       = ONE << sh;
        g       = b >> sh;
        p       = b & (h - ONE);
        a       = ((g << sh) << 1) + p;
        b_addr  = a + h;
        rev_in  = '0;
        rev_out = '0;
        tw      = p << inv_s;
        unique case (1'b1)
            mode == MODE_DIF: begin
                rev_in  = MAX_LOG_N'((ONE << s) + g);
                rev_out = bit_reverse(rev_in, LOG_N);
                tw      = rev_out[LOG_N-1:0];
            end
            mode == MODE_INV: begin
                rev_in  = MAX_LOG_N'((ONE << inv_s) + g);
                rev_out = bit_reverse(rev_in, LOG_N);
                tw      = rev_out[LOG_N-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ntt_sequencer.sv
// ntt_sequencer: issue/drain FSM for in-place radix-2 NTT/INTT.
// One butterfly read per cycle; write-back via a stall-aware delay line.
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int LOG_N      = 8,
    parameter int BF_LATENCY = 3
) (
    input  logic           clk,
    input  logic           rst,
    ntt_sequencer_if.slave sif
);
    localparam int SW = $clog2(LOG_N);
    localparam int DW = $clog2(BF_LATENCY + 1);
    localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);
    localparam logic [LOG_N-1:0] B_LAST = LOG_N'((1 << (LOG_N - 1)) - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(BF_LATENCY - 1);

    seq_state_t       state;
    ntt_mode_t        mode_q;
    logic [SW-1:0]    s_q;
    logic [LOG_N-1:0] b_q;
    logic [DW-1:0]    d_q;
    logic             err_q;
    logic             issuing, active, kill;
    logic [LOG_N-1:0] a, b_addr, tw;
    logic             dl_en [BF_LATENCY];
    logic [LOG_N-1:0] dl_a  [BF_LATENCY];
    logic [LOG_N-1:0] dl_b  [BF_LATENCY];

    ntt_addr_gen #(.LOG_N(LOG_N)) u_addr (
        .mode   (mode_q),
        .s      (s_q),
        .b      (b_q),
        .a      (a),
        .b_addr (b_addr),
        .tw     (tw)
    );

    assign issuing = (state == ST_ISSUE);
    assign active  = issuing || (state == ST_DRAIN);
    assign kill    = active && sif.abort;

    // Addresses are zeroed outside ISSUE so reset and idle show all-zero outputs.
    assign sif.busy      = active;
    assign sif.done      = (state == ST_DONE) && !sif.stall;
    assign sif.err       = err_q;
    assign sif.rd_en     = issuing && !sif.stall;
    assign sif.rd_addr_a = issuing ? a : '0;
    assign sif.rd_addr_b = issuing ? b_addr : '0;
    assign sif.tw_addr   = issuing ? tw : '0;
    assign sif.wr_en     = dl_en[BF_LATENCY-1] && !sif.stall;
    assign sif.wr_addr_a = dl_a[BF_LATENCY-1];
    assign sif.wr_addr_b = dl_b[BF_LATENCY-1];
    assign sif.stage_idx = s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode_q <= MODE_DIT;
            s_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (kill) begin
                state <= ST_IDLE;
                s_q   <= '0;
                b_q   <= '0;
                d_q   <= '0;
            end else if (!sif.stall) begin
                unique case (state)
                    ST_IDLE: begin
                        if (sif.start && !sif.abort) begin
                            if (sif.mode == MODE_ILL) begin
                                err_q <= 1'b1;
                            end else begin
                                state  <= ST_ISSUE;
                                mode_q <= ntt_mode_t'(sif.mode);
                                s_q    <= '0;
                                b_q    <= '0;
                                d_q    <= '0;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (b_q == B_LAST) begin
                            b_q   <= '0;
                            d_q   <= '0;
                            state <= ST_DRAIN;
                        end else begin
                            b_q <= b_q + LOG_N'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (d_q == D_LAST) begin
                            d_q <= '0;
                            if (s_q == S_LAST) begin
                                state <= ST_DONE;
                            end else begin
                                s_q   <= s_q + SW'(1);
                                state <= ST_ISSUE;
                            end
                        end else begin
                            d_q <= d_q + DW'(1);
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        s_q   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                dl_en[i] <= 1'b0;
                dl_a[i]  <= '0;
                dl_b[i]  <= '0;
            end
        end else if (kill) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                dl_en[i] <= 1'b0;
                dl_a[i]  <= '0;
                dl_b[i]  <= '0;
            end
        end else if (!sif.stall) begin
            dl_en[0] <= issuing;
            dl_a[0]  <= sif.rd_addr_a;
            dl_b[0]  <= sif.rd_addr_b;
            for (int i = BF_LATENCY - 1; i > 0; i--) begin
                dl_en[i] <= dl_en[i-1];
                dl_a[i]  <= dl_a[i-1];
                dl_b[i]  <= dl_b[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_sequencer.sv
// tb_ntt_sequencer: address-table vectors plus directed control sequences.
// Expected values are hand-computed or come from a small DIT index model.
module tb_ntt_sequencer;
    import ntt_pkg::*;

    localparam int LN = 8;
    localparam int BF = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_sequencer_if #(.LOG_N(LN)) sif ();

    ntt_sequencer #(.LOG_N(LN), .BF_LATENCY(BF)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    ntt_mode_t  ag_mode;
    logic [1:0] ag_s;
    logic [2:0] ag_b, ag_a, ag_ba, ag_tw;

    ntt_addr_gen #(.LOG_N(3)) u_ag (
        .mode   (ag_mode),
        .s      (ag_s),
        .b      (ag_b),
        .a      (ag_a),
        .b_addr (ag_ba),
        .tw     (ag_tw)
    );

    typedef struct {
        logic [1:0] mode;
        logic [1:0] s;
        logic [2:0] b;
        logic [2:0] a;
        logic [2:0] ba;
        logic [2:0] tw;
    } ag_vec_t;

    ag_vec_t vecs [10];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int   busy_cyc, done_cnt, done_bad, wr_cnt, rd_cnt;
    int   wb_bad, addr_bad;
    bit   chk_wb, chk_addr;
    int   es, eb, mh, mg, mp;
    logic prev_busy;
    logic [16:0] hist [3];

    initial begin
        busy_cyc = 0; done_cnt = 0; done_bad = 0; wr_cnt = 0; rd_cnt = 0;
        wb_bad = 0; addr_bad = 0; chk_wb = 0; chk_addr = 0;
        es = 0; eb = 0; prev_busy = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            if (sif.busy) busy_cyc++;
            if (sif.done) begin
                done_cnt++;
                if (!prev_busy || sif.busy) done_bad++;
            end
            if (sif.wr_en) wr_cnt++;
            if (sif.rd_en) rd_cnt++;
            if (chk_wb && !sif.stall) begin
                if ((sif.wr_en || hist[2][16]) &&
                    {sif.wr_en, sif.wr_addr_a, sif.wr_addr_b} !== hist[2])
                    wb_bad++;
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = {sif.rd_en, sif.rd_addr_a, sif.rd_addr_b};
            end
            if (chk_addr && sif.rd_en) begin
                mh = 1 << es;
                mg = eb / mh;
                mp = eb % mh;
                if (sif.rd_addr_a !== 8'(mg * 2 * mh + mp) ||
                    sif.rd_addr_b !== 8'(mg * 2 * mh + mp + mh) ||
                    sif.tw_addr !== 8'(mp << (LN - 1 - es)) ||
                    sif.stage_idx !== 3'(es))
                    addr_bad++;
                eb++;
                if (eb == 128) begin
                    eb = 0;
                    es++;
                end
            end
            prev_busy = sif.busy;
        end
    end

    task automatic clear_counts();
        busy_cyc = 0; done_cnt = 0; done_bad = 0; wr_cnt = 0; rd_cnt = 0;
    endtask

    task automatic do_start(input logic [1:0] m);
        @(posedge clk); #1;
        clear_counts();
        sif.start = 1'b1;
        sif.mode  = m;
        @(posedge clk); #1;
        sif.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!sif.done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(sif.done), 1);
    endtask

    task automatic do_abort();
        @(posedge clk); #1;
        sif.abort = 1'b1;
        @(posedge clk); #1;
        sif.abort = 1'b0;
    endtask

    logic [7:0] ha, hb, ht;

    initial begin
        int guard;
        sif.start = 1'b0;
        sif.mode  = 2'd0;
        sif.stall = 1'b0;
        sif.abort = 1'b0;

        vecs[0] = '{2'd0, 2'd0, 3'd0, 3'd0, 3'd1, 3'd0};
        vecs[1] = '{2'd0, 2'd2, 3'd3, 3'd3, 3'd7, 3'd3};
        vecs[2] = '{2'd0, 2'd1, 3'd3, 3'd5, 3'd7, 3'd2};
        vecs[3] = '{2'd0, 2'd0, 3'd2, 3'd4, 3'd5, 3'd0};
        vecs[4] = '{2'd1, 2'd0, 3'd1, 3'd1, 3'd5, 3'd4};
        vecs[5] = '{2'd1, 2'd2, 3'd3, 3'd6, 3'd7, 3'd7};
        vecs[6] = '{2'd1, 2'd1, 3'd2, 3'd4, 3'd6, 3'd6};
        vecs[7] = '{2'd2, 2'd0, 3'd2, 3'd4, 3'd5, 3'd3};
        vecs[8] = '{2'd2, 2'd2, 3'd1, 3'd1, 3'd5, 3'd4};
        vecs[9] = '{2'd2, 2'd1, 3'd3, 3'd5, 3'd7, 3'd6};

        for (int i = 0; i < 10; i++) begin
            ag_mode = ntt_mode_t'(vecs[i].mode);
            ag_s    = vecs[i].s;
            ag_b    = vecs[i].b;
            #1;
            check($sformatf("ag%0d_a", i), 32'(ag_a), 32'(vecs[i].a));
            check($sformatf("ag%0d_b", i), 32'(ag_ba), 32'(vecs[i].ba));
            check($sformatf("ag%0d_tw", i), 32'(ag_tw), 32'(vecs[i].tw));
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({sif.busy, sif.done, sif.err, sif.rd_en,
                                 sif.wr_en, sif.stage_idx}), 0);
        check("reset_addr", 32'(sif.rd_addr_a | sif.rd_addr_b | sif.tw_addr |
                                sif.wr_addr_a | sif.wr_addr_b), 0);
        rst = 1'b0;

        // Full DIT run with write-back and address model checks.
        chk_wb = 1; chk_addr = 1; es = 0; eb = 0;
        do_start(2'd0);
        @(negedge clk);
        check("first_rd_en", 32'(sif.rd_en), 1);
        check("first_rd_b", 32'(sif.rd_addr_b), 1);
        check("first_busy", 32'(sif.busy), 1);
        wait_done("full_done_seen");
        check("full_busy_cycles", busy_cyc, 1048);
        check("full_busy_at_done", 32'(sif.busy), 0);
        @(negedge clk);
        check("full_done_single", 32'(sif.done), 0);
        check("full_done_count", done_cnt, 1);
        check("full_done_after_busy", done_bad, 0);
        check("full_wr_count", wr_cnt, 1024);
        check("full_rd_count", rd_cnt, 1024);
        check("full_wb_delay", wb_bad, 0);
        check("full_addr_model", addr_bad, 0);
        chk_wb = 0; chk_addr = 0;

        // Stall five cycles in the middle of stage 3.
        do_start(2'd0);
        guard = 0;
        while (!(sif.stage_idx == 3'd3 && sif.rd_en) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("stall_reach_s3", 32'(sif.stage_idx), 3);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        sif.stall = 1'b1;
        #1;
        ha = sif.rd_addr_a; hb = sif.rd_addr_b; ht = sif.tw_addr;
        repeat (5) begin
            @(negedge clk);
            check("stall_quiet", 32'({sif.rd_en, sif.wr_en}), 0);
            check("stall_hold", 32'(sif.rd_addr_a == ha && sif.rd_addr_b == hb &&
                                    sif.tw_addr == ht), 1);
            @(posedge clk);
        end
        #1;
        sif.stall = 1'b0;
        @(negedge clk);
        check("stall_resume_rd", 32'(sif.rd_en), 1);
        check("stall_resume_addr", 32'(sif.rd_addr_a), 32'(ha));
        wait_done("stall_done_seen");
        check("stall_busy_cycles", busy_cyc, 1053);

        // Abort while draining stage 0.
        do_start(2'd0);
        guard = 0;
        while (!(sif.busy && !sif.rd_en) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("abort_in_drain", 32'({sif.busy, sif.rd_en}), 2);
        do_abort();
        @(negedge clk);
        check("abort_busy", 32'(sif.busy), 0);
        clear_counts();
        repeat (30) @(negedge clk);
        check("abort_no_wr", wr_cnt, 0);
        check("abort_no_done", done_cnt, 0);

        // Illegal mode is rejected with a single err pulse.
        @(posedge clk); #1;
        sif.start = 1'b1;
        sif.mode  = 2'd3;
        @(posedge clk); #1;
        sif.start = 1'b0;
        @(negedge clk);
        check("ill_err", 32'(sif.err), 1);
        check("ill_busy", 32'(sif.busy), 0);
        @(negedge clk);
        check("ill_err_pulse", 32'(sif.err), 0);
        check("ill_busy_later", 32'(sif.busy), 0);

        // Asynchronous reset in the middle of ISSUE.
        do_start(2'd0);
        repeat (20) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'({sif.busy, sif.done, sif.err, sif.rd_en,
                                   sif.wr_en, sif.stage_idx}), 0);
        check("rst_mid_addr", 32'(sif.rd_addr_a | sif.rd_addr_b | sif.tw_addr |
                                  sif.wr_addr_a | sif.wr_addr_b), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fresh DIF run starts at s0 b0.
        do_start(2'd1);
        @(negedge clk);
        check("dif_first_rd", 32'(sif.rd_en), 1);
        check("dif_first_stage", 32'(sif.stage_idx), 0);
        check("dif_first_a", 32'(sif.rd_addr_a), 0);
        check("dif_first_b", 32'(sif.rd_addr_b), 128);
        check("dif_first_tw", 32'(sif.tw_addr), 128);
        do_abort();

        // start held high through DONE only retriggers from IDLE.
        @(posedge clk); #1;
        clear_counts();
        sif.start = 1'b1;
        sif.mode  = 2'd0;
        wait_done("held_done_seen");
        check("held_busy_cycles", busy_cyc, 1048);
        @(negedge clk);
        check("held_idle_gap", 32'(sif.busy), 0);
        @(negedge clk);
        check("held_restart", 32'(sif.busy), 1);
        @(posedge clk); #1;
        sif.start = 1'b0;
        do_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
